// File: rtl/ov7670_pkg.sv
// Shared encodings and default timing for the OV7670 capture front-end.
package ov7670_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FRAME = 2'd1,
        WAIT_LINE  = 2'd2,
        READ       = 2'd3
    } state_t;

    localparam int H_ACTIVE_VGA  = 640;
    localparam int V_ACTIVE_VGA  = 480;
    localparam int H_ACTIVE_QVGA = 320;
    localparam int V_ACTIVE_QVGA = 240;

    // Byte phase counter width; covers up to four bytes per pixel.
    localparam int PHASE_W = 2;

endpackage

// File: rtl/ov7670_pixel_pack.sv
// Collects BPP camera bytes into one pixel word; done is combinational with the last byte.
module ov7670_pixel_pack
    import ov7670_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int BPP    = 2
) (
    input  logic                    pclk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    shift_en,
    input  logic                    swap,
    input  logic [DATA_W-1:0]       byte_in,
    output logic [DATA_W*BPP-1:0]   word,
    output logic                    done,
    output logic [PHASE_W-1:0]      phase
);

    logic [DATA_W-1:0]  bytes_q [BPP];
    logic [DATA_W-1:0]  full    [BPP];
    logic [PHASE_W-1:0] phase_eff;

    assign phase_eff = clear ? '0 : phase;
    assign done      = shift_en && (phase_eff == PHASE_W'(BPP - 1));

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            phase <= '0;
            for (int i = 0; i < BPP; i++) bytes_q[i] <= '0;
        end else if (shift_en) begin
            for (int i = 0; i < BPP; i++) begin
                if (phase_eff == PHASE_W'(i)) bytes_q[i] <= byte_in;
            end
            phase <= done ? '0 : phase_eff + 1'b1;
        end
    end

    // The final byte bypasses the register so the pixel is ready in the same cycle.
    always_comb begin
        for (int i = 0; i < BPP; i++) full[i] = (i == BPP - 1) ? byte_in : bytes_q[i];
    end

    always_comb begin
        word = '0;
        for (int i = 0; i < BPP; i++) begin
            if (swap) word[i*DATA_W +: DATA_W]           = full[i];
            else      word[(BPP-1-i)*DATA_W +: DATA_W]   = full[i];
        end
    end

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 DVP capture: byte packing, x/y tracking, frame markers and length checks.
// state      | meaning
// IDLE       | disarmed, waiting for vsync high
// WAIT_FRAME | vsync seen, waiting for its falling edge
// WAIT_LINE  | inside a frame, waiting for href
// READ       | shifting in line bytes
module ov7670_capture
    import ov7670_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int BYTES_PER_PIX = 2,
    parameter int H_ACTIVE      = H_ACTIVE_VGA,
    parameter int V_ACTIVE      = V_ACTIVE_VGA,
    parameter int X_W           = 10,
    parameter int Y_W           = 9,
    parameter int FCNT_W        = 16
) (
    input  logic                              pclk,
    input  logic                              reset,
    input  logic [DATA_W-1:0]                 din,
    input  logic                              vsync,
    input  logic                              href,
    input  logic                              capture_en,
    input  logic                              swap_bytes,
    input  logic                              decim_en,
    output logic [DATA_W*BYTES_PER_PIX-1:0]   pix_data,
    output logic                              pix_valid,
    output logic [X_W-1:0]                    pix_x,
    output logic [Y_W-1:0]                    pix_y,
    output logic                              sof,
    output logic                              eol,
    output logic                              eof,
    output logic                              line_err,
    output logic                              frame_err,
    output logic [FCNT_W-1:0]                 frame_cnt
);

    localparam logic [X_W-1:0] X_MAX  = X_W'(H_ACTIVE);
    localparam logic [Y_W-1:0] Y_MAX  = Y_W'(V_ACTIVE);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_ACTIVE - 1);

    logic [DATA_W-1:0] din_q;
    logic              href_q, vsync_q, vsync_d;
    state_t            state, state_nxt;
    logic [X_W-1:0]    x, x_cur;
    logic [Y_W-1:0]    y;
    logic              decim_q, first_pix;
    logic              vsync_fall, in_frame, abort, line_end, frame_start;
    logic              shift_en, pack_clear, pack_done, emit;
    logic [PHASE_W-1:0]                 phase;
    logic [DATA_W*BYTES_PER_PIX-1:0]    pack_word;

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            din_q   <= '0;
            href_q  <= 1'b0;
            vsync_q <= 1'b0;
            vsync_d <= 1'b0;
        end else begin
            din_q   <= din;
            href_q  <= href;
            vsync_q <= vsync;
            vsync_d <= vsync_q;
        end
    end

    assign vsync_fall = vsync_d & ~vsync_q;

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (vsync_q) state_nxt = WAIT_FRAME;
            WAIT_FRAME: if (vsync_fall) state_nxt = capture_en ? WAIT_LINE : IDLE;
            WAIT_LINE:  if (vsync_q) state_nxt = WAIT_FRAME;
                        else if (href_q) state_nxt = READ;
            READ:       if (vsync_q) state_nxt = WAIT_FRAME;
                        else if (!href_q) state_nxt = (y == Y_LAST) ? WAIT_FRAME : WAIT_LINE;
            default:    state_nxt = IDLE;
        endcase
    end

    // vsync wins over a coincident href fall, so line_end excludes it.
    always_comb begin
        in_frame    = (state == WAIT_LINE) || (state == READ);
        abort       = in_frame && vsync_q;
        frame_start = (state == WAIT_FRAME) && vsync_fall && capture_en;
        line_end    = (state == READ) && !vsync_q && !href_q;
        shift_en    = in_frame && !vsync_q && href_q;
        pack_clear  = (state == WAIT_LINE);
        x_cur       = (state == WAIT_LINE) ? '0 : x;
        emit        = pack_done && (x_cur < X_MAX) && (!decim_q || (!x_cur[0] && !y[0]));
    end

    ov7670_pixel_pack #(
        .DATA_W (DATA_W),
        .BPP    (BYTES_PER_PIX)
    ) u_pack (
        .pclk     (pclk),
        .reset    (reset),
        .clear    (pack_clear),
        .shift_en (shift_en),
        .swap     (swap_bytes),
        .byte_in  (din_q),
        .word     (pack_word),
        .done     (pack_done),
        .phase    (phase)
    );

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            x         <= '0;
            y         <= '0;
            decim_q   <= 1'b0;
            first_pix <= 1'b0;
            pix_data  <= '0;
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            sof       <= 1'b0;
            eol       <= 1'b0;
            eof       <= 1'b0;
            line_err  <= 1'b0;
            frame_err <= 1'b0;
            frame_cnt <= '0;
        end else begin
            pix_valid <= 1'b0;
            sof       <= 1'b0;
            eol       <= 1'b0;
            eof       <= 1'b0;
            line_err  <= 1'b0;
            frame_err <= 1'b0;
            if (frame_start) begin
                decim_q   <= decim_en;
                y         <= '0;
                first_pix <= 1'b1;
            end
            if (shift_en) x <= (pack_done && (x_cur != X_MAX)) ? x_cur + 1'b1 : x_cur;
            if (emit) begin
                pix_valid <= 1'b1;
                pix_data  <= pack_word;
                pix_x     <= decim_q ? (x_cur >> 1) : x_cur;
                pix_y     <= decim_q ? (y >> 1) : y;
                sof       <= first_pix;
                first_pix <= 1'b0;
            end
            if (line_end) begin
                line_err <= (x != X_MAX) || (phase != '0);
                eol      <= 1'b1;
                y        <= y + 1'b1;
                if (y == Y_LAST) begin
                    eof       <= 1'b1;
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
            if (abort) frame_err <= (y < Y_MAX) && ((y != '0) || (state == READ));
        end
    end

endmodule
